// File: rtl/bus_driver.sv
// Internal-bus write driver: priority-selects one byte source onto a registered bus
// with a hold window, 0xFF precharge and contention tracking. Optional busParity via BUS_DRIVER_PARITY_EN.
module bus_driver #(
  parameter int                 SOURCE_COUNT    = 4,
  parameter int                 WIDTH           = 8,
  parameter int                 HOLD_CYCLES     = 2,
  parameter logic [WIDTH-1:0]   PRECHARGE_VALUE = {WIDTH{1'b1}}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH*SOURCE_COUNT-1:0]  sourceInputs,
  input  logic [SOURCE_COUNT-1:0]        sourceWriteEnable,
  input  logic                           clearContention,
  output logic [WIDTH-1:0]               busOutput,
  output logic                           busValid,
  output logic [1:0]                     busState,
  output logic                           contentionFlag,
`ifdef BUS_DRIVER_PARITY_EN
  output logic                           busParity,
`endif
  output logic [7:0]                     contentionCount
);

  localparam logic [1:0] ST_PRECHARGED = 2'b00;
  localparam logic [1:0] ST_DRIVEN     = 2'b01;
  localparam logic [1:0] ST_HOLDING    = 2'b10;

  localparam int             HW       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [7:0]       cnt_q, cnt_d, cnt_base;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] sel_byte;
  logic             any_en;
  logic             multi_en;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    sel_byte = '0;
    // Ascending scan: the last (highest-indexed) enabled source overwrites the rest.
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      if (sourceWriteEnable[i]) sel_byte = sourceInputs[WIDTH*i +: WIDTH];
    end
  end

  assign any_en   = |sourceWriteEnable;
  assign multi_en = $countones(sourceWriteEnable) > 1;

  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    hold_d  = hold_q;
    if (any_en) begin
      state_d = ST_DRIVEN;
      bus_d   = sel_byte;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_DRIVEN: begin
          if (HOLD_CYCLES == 0) begin
            state_d = ST_PRECHARGED;
            bus_d   = PRECHARGE_VALUE;
          end else begin
            state_d = ST_HOLDING;
            hold_d  = HW'(1);
          end
        end
        ST_HOLDING: begin
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
          end else begin
            state_d = ST_PRECHARGED;
            bus_d   = PRECHARGE_VALUE;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = ST_PRECHARGED;
          bus_d   = PRECHARGE_VALUE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Clear takes effect before this edge's contention, so both together leave count = 1.
  always_comb begin
    cnt_base = clearContention ? 8'd0 : cnt_q;
    cnt_d    = (multi_en && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    flag_d   = (clearContention ? 1'b0 : flag_q) | multi_en;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PRECHARGED;
      bus_q   <= PRECHARGE_VALUE;
      hold_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

`ifdef BUS_DRIVER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= ^PRECHARGE_VALUE;
    else     parity_q <= ^bus_d;
  end

  assign busParity = parity_q;
`endif

  assign busOutput       = bus_q;
  assign busState        = state_q;
  assign busValid        = (state_q == ST_DRIVEN);
  assign contentionFlag  = flag_q;
  assign contentionCount = cnt_q;

endmodule

// File: tb/tb_bus_driver.sv
// Self-checking bench for bus_driver: directed test-plan steps plus randomized traffic
// compared against a cycle-age reference model of the bus.
module tb_bus_driver;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sourceInputs;
  logic [3:0]  sourceWriteEnable;
  logic        clearContention;
  logic [7:0]  busOutput;
  logic        busValid;
  logic [1:0]  busState;
  logic        contentionFlag;
  logic [7:0]  contentionCount;
`ifdef BUS_DRIVER_PARITY_EN
  logic        busParity;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: bus value is a function of how many edges ago the last drive happened.
  bit         m_driven;
  int         m_age;
  logic [7:0] m_last;
  int         m_cnt;
  bit         m_flag;

  bus_driver dut (
    .clk               (clk),
    .rst               (rst),
    .sourceInputs      (sourceInputs),
    .sourceWriteEnable (sourceWriteEnable),
    .clearContention   (clearContention),
    .busOutput         (busOutput),
    .busValid          (busValid),
    .busState          (busState),
    .contentionFlag    (contentionFlag),
`ifdef BUS_DRIVER_PARITY_EN
    .busParity         (busParity),
`endif
    .contentionCount   (contentionCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_driven = 1'b0;
    m_age    = 0;
    m_last   = 8'hFF;
    m_cnt    = 0;
    m_flag   = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] en, input logic [31:0] src, input logic clr);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (en[i]) n++;
    if (n > 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (en[i]) begin
          m_last = src[8*i +: 8];
          break;
        end
      end
      m_driven = 1'b1;
      m_age    = 0;
    end else begin
      m_age++;
    end
    if (clr) begin
      m_cnt  = 0;
      m_flag = 1'b0;
    end
    if (n >= 2) begin
      m_flag = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_bus;
    logic [1:0] e_state;
    if (!m_driven || m_age > HOLD) begin
      e_bus   = 8'hFF;
      e_state = 2'b00;
    end else if (m_age == 0) begin
      e_bus   = m_last;
      e_state = 2'b01;
    end else begin
      e_bus   = m_last;
      e_state = 2'b10;
    end
    check({tag, ".bus"},   busOutput,       e_bus);
    check({tag, ".state"}, busState,        e_state);
    check({tag, ".valid"}, busValid,        (e_state == 2'b01));
    check({tag, ".flag"},  contentionFlag,  m_flag);
    check({tag, ".count"}, contentionCount, m_cnt);
`ifdef BUS_DRIVER_PARITY_EN
    check({tag, ".par"},   busParity,       ^e_bus);
`endif
  endtask

  task automatic step(input string tag, input logic [3:0] en, input logic [31:0] src,
                      input logic clr);
    @(negedge clk);
    sourceWriteEnable = en;
    sourceInputs      = src;
    clearContention   = clr;
    @(posedge clk);
    model_edge(en, src, clr);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst               = 1'b1;
    sourceInputs      = '0;
    sourceWriteEnable = '0;
    clearContention   = 1'b0;
    model_reset();
    #3;
    check_model("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset release.
    for (int i = 0; i < 5; i++) step("idle", 4'b0000, 32'h0, 1'b0);

    // Single drive of source 2, then the hold window and precharge.
    step("drv3c", 4'b0100, 32'h003C_0000, 1'b0);
    check("drv3c_bus", busOutput, 8'h3C);
    check("drv3c_valid", busValid, 1'b1);
    step("hold1", 4'b0000, 32'h0, 1'b0);
    check("hold1_state", busState, 2'b10);
    step("hold2", 4'b0000, 32'h0, 1'b0);
    check("hold2_bus", busOutput, 8'h3C);
    step("pre", 4'b0000, 32'h0, 1'b0);
    check("pre_bus", busOutput, 8'hFF);

    // Contention: 1011 picks index 3, then saturation at 255.
    step("cont1", 4'b1011, 32'hAA55_1122, 1'b0);
    check("cont1_bus", busOutput, 8'hAA);
    check("cont1_count", contentionCount, 8'd1);
    for (int i = 0; i < 299; i++) step("cont_sat", 4'b1011, 32'hAA55_1122, 1'b0);
    check("sat_count", contentionCount, 8'd255);

    // Re-drive during HOLDING restarts the full hold window.
    step("clr0", 4'b0000, 32'h0, 1'b1);
    step("drv10", 4'b0001, 32'h0000_0010, 1'b0);
    step("hold10", 4'b0000, 32'h0, 1'b0);
    step("drv20", 4'b0001, 32'h0000_0020, 1'b0);
    check("drv20_bus", busOutput, 8'h20);
    check("drv20_state", busState, 2'b01);
    step("hold20a", 4'b0000, 32'h0, 1'b0);
    step("hold20b", 4'b0000, 32'h0, 1'b0);
    check("hold20b_bus", busOutput, 8'h20);
    step("pre20", 4'b0000, 32'h0, 1'b0);

    // Clear coinciding with contention at count 7.
    for (int i = 0; i < 7; i++) step("cont7", 4'b0011, 32'h0000_5566, 1'b0);
    check("cont7_count", contentionCount, 8'd7);
    step("clr_cont", 4'b0011, 32'h0000_5566, 1'b1);
    check("clr_cont_count", contentionCount, 8'd1);
    check("clr_cont_flag", contentionFlag, 1'b1);
    step("clr_only", 4'b0000, 32'h0, 1'b1);
    check("clr_only_count", contentionCount, 8'd0);
    check("clr_only_flag", contentionFlag, 1'b0);

    // Asynchronous reset in the middle of HOLDING 0x77.
    step("drv77", 4'b0011, 32'h0000_7700, 1'b0);
    step("hold77", 4'b0000, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_bus", busOutput, 8'hFF);
    check("arst_state", busState, 2'b00);
    check("arst_valid", busValid, 1'b0);
    check("arst_count", contentionCount, 8'd0);
    check("arst_flag", contentionFlag, 1'b0);
`ifdef BUS_DRIVER_PARITY_EN
    check("arst_par", busParity, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4'b0000, 32'h0, 1'b0);
    step("drv07", 4'b1000, 32'h0700_0000, 1'b0);
`ifdef BUS_DRIVER_PARITY_EN
    check("drv07_par", busParity, 1'b1);
`endif

    // Randomized traffic with bursts of idle cycles to exercise hold/precharge.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step("rand", en, $urandom, ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
